hdmi_pixel_fetch: RTL and testbench
===================================

// Module: hdmi_pixel_fetch
// PURPOSE
//  Downstream consumer of the DMT timing generator; sits between it and the TMDS encoder.
//  Takes raw vsync/hsync/de and pops RGB565 pixels from the frame-buffer read FIFO on every de cycle.
//  Expands each pixel to RGB888 and re-times sync/de so they stay aligned with the pixel data.
//  Detects FIFO underflow, blanks the rest of that frame with a fill colour, and requests a
//  frame-buffer restart on every vsync leading edge.
// PARAMETERS
//  RD_LAT      1          FIFO read latency in cycles, fifo_rd -> fifo_rdata valid (legal values 1..3)
//  HS_POL      1'b1       active level of hsync_in/hsync
//  VS_POL      1'b1       active level of vsync_in/vsync
//  FILL_COLOR  24'h000000 RGB888 driven during de when no valid pixel is available
// PORTS
//  pixe_clk       in   1   pixel clock; single clock domain
//  rest_n         in   1   asynchronous active-low reset
//  vsync_in       in   1   vsync from timing generator
//  hsync_in       in   1   hsync from timing generator
//  de_in          in   1   data enable from timing generator
//  fifo_rdata     in   16  RGB565 pixel {R5,G6,B5} from read FIFO
//  fifo_empty     in   1   read FIFO empty
//  fifo_rd        out  1   FIFO pop strobe, one pixel per cycle
//  frame_req      out  1   1-cycle pulse: upstream flushes FIFO, restarts at frame-buffer address 0
//  vsync          out  1   vsync, delayed and aligned to rgb
//  hsync          out  1   hsync, delayed and aligned to rgb
//  de             out  1   de, delayed and aligned to rgb
//  rgb            out  24  {R8,G8,B8} pixel
//  underflow_cnt  out  16  count of underflow events; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rest_n=0)
//   - vsync=~VS_POL, hsync=~HS_POL, de=0, rgb=0, fifo_rd=0, frame_req=0, underflow_cnt=0
//   - state=IDLE, all delay stages cleared to their inactive values
//   - reset asserted mid-frame takes effect immediately; no partial pixel is emitted
//  Vsync edge detect
//   - vs_prev register, reset value ~VS_POL
//   - vs_lead = (vsync_in==VS_POL) && (vs_prev!=VS_POL)
//  FSM: IDLE, WAIT, STREAM, FILL
//   - vs_lead in any state -> frame_req=1 for that cycle; next state WAIT
//     (vs_lead has priority over every other transition)
//   - IDLE:   fifo_rd=0; leaves only on vs_lead
//   - WAIT:   fifo_rd=0
//       -> STREAM when vsync_in!=VS_POL and fifo_empty==0
//       -> FILL with underflow_cnt+1 if de_in=1 while still in WAIT
//   - STREAM: fifo_rd = de_in & ~fifo_empty
//       -> FILL with underflow_cnt+1 if de_in=1 and fifo_empty=1
//   - FILL:   fifo_rd=0 until the next vs_lead; one increment per event, not per pixel
//  Pipeline
//   - vsync_in/hsync_in/de_in pass through RD_LAT+1 register stages to vsync/hsync/de
//   - a valid bit (=fifo_rd) travels RD_LAT stages beside them
//   - output register updates each cycle:
//       de_d=1 & valid_d=1 -> rgb = {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}  (MSB replication)
//       de_d=1 & valid_d=0 -> rgb = FILL_COLOR
//       de_d=0             -> rgb = 24'h0
//   - total input-to-output latency fixed at RD_LAT+1 cycles for sync, de and rgb
//  Arithmetic / boundaries
//   - underflow_cnt increment saturates; no wrap
//   - fifo_rd is never asserted while fifo_empty=1 or de_in=0
//   - frame_req and fifo_rd are never both 1 in the same cycle
//   - de_in rising and fifo_empty deasserting in the same cycle while in WAIT -> underflow (FILL)
// TESTING
//  T1  RD_LAT=1, reset, 8x4 active frame, FIFO preloaded 0..31
//      -> rgb tracks data, 2-cycle latency; pixel 16'hF800 -> rgb 24'hFF0000
//  T2  vs_lead while in STREAM
//      -> exactly one frame_req pulse, fifo_rd=0 until vsync_in inactive, state WAIT
//  T3  FIFO empties at pixel 5 of line 2
//      -> FILL_COLOR from that pixel to frame end; underflow_cnt=1; next frame streams normally
//  T4  FIFO held empty for 3 frames
//      -> underflow_cnt=3; de/hsync/vsync timing unchanged
//  T5  rest_n pulsed low mid-line
//      -> all outputs reset values immediately; IDLE; no fifo_rd until vs_lead then WAIT->STREAM
//  T6  RD_LAT=3 rerun of T1, plus underflow_cnt preset near max
//      -> 4-cycle alignment; underflow_cnt saturates at 16'hFFFF

Source files
------------

// File: rtl/hdmi_pixel_fetch_if.sv
// Video/FIFO bundle between the DMT timing generator, the frame-buffer read
// FIFO and the TMDS encoder. slave = pixel fetch block, master = its environment.
interface hdmi_pixel_fetch_if;
  logic        vsync_in;
  logic        hsync_in;
  logic        de_in;
  logic [15:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        frame_req;
  logic        vsync;
  logic        hsync;
  logic        de;
  logic [23:0] rgb;
  logic [15:0] underflow_cnt;

  modport master (
    output vsync_in, hsync_in, de_in, fifo_rdata, fifo_empty,
    input  fifo_rd, frame_req, vsync, hsync, de, rgb, underflow_cnt
  );

  modport slave (
    input  vsync_in, hsync_in, de_in, fifo_rdata, fifo_empty,
    output fifo_rd, frame_req, vsync, hsync, de, rgb, underflow_cnt
  );
endinterface

// File: rtl/hdmi_pixel_fetch.sv
// Pixel fetch between DMT timing and TMDS encoder: pops RGB565 from the
// frame-buffer FIFO during de, expands to RGB888, re-times sync/de to match,
// and blanks the remainder of a frame with FILL_COLOR after a FIFO underflow.
module hdmi_pixel_fetch #(
  parameter int          RD_LAT     = 1,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1,
  parameter logic [23:0] FILL_COLOR = 24'h000000,
  // reset value of underflow_cnt; nonzero only to reach saturation quickly
  parameter logic [15:0] UFL_INIT   = 16'h0000
) (
  input logic               pixe_clk,
  input logic               rest_n,
  hdmi_pixel_fetch_if.slave pf
);

  localparam int SD = RD_LAT + 1;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, FILL} state_t;

  state_t      state;
  logic        vs_prev;
  logic        vs_lead;
  logic        fifo_rd_c;
  logic [15:0] ufl_cnt;

  logic [SD:1]     vs_pipe;
  logic [SD:1]     hs_pipe;
  logic [SD:1]     de_pipe;
  logic [RD_LAT:1] vld_pipe;
  logic [23:0]     rgb_q;

  logic        de_d;
  logic        valid_d;
  logic [15:0] px;

  assign vs_lead = (pf.vsync_in == VS_POL) && (vs_prev != VS_POL);

  // Pop and restart strobes must act in the same cycle as the de/vsync that
  // causes them, so they are decoded from the registered state, not registered.
  always_comb begin
    fifo_rd_c = 1'b0;
    if (!vs_lead && state == STREAM)
      fifo_rd_c = pf.de_in & ~pf.fifo_empty;
  end

  assign pf.fifo_rd   = fifo_rd_c;
  assign pf.frame_req = vs_lead;

  // Frame FSM: restart on every vsync leading edge, latch into FILL on underflow
  always_ff @(posedge pixe_clk or negedge rest_n) begin
    if (!rest_n) begin
      state   <= IDLE;
      vs_prev <= ~VS_POL;
      ufl_cnt <= UFL_INIT;
    end else begin
      vs_prev <= pf.vsync_in;
      if (vs_lead) begin
        state <= WAIT;
      end else begin
        case (state)
          WAIT: begin
            // de arriving before streaming could start counts as underflow,
            // even if the FIFO becomes non-empty in that same cycle
            if (pf.de_in) begin
              state <= FILL;
              if (ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
            end else if (pf.vsync_in != VS_POL && !pf.fifo_empty) begin
              state <= STREAM;
            end
          end
          STREAM: begin
            if (pf.de_in && pf.fifo_empty) begin
              state <= FILL;
              if (ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sync/de delay line (RD_LAT+1) and pixel-valid delay line (RD_LAT)
  always_ff @(posedge pixe_clk or negedge rest_n) begin
    if (!rest_n) begin
      vs_pipe  <= {SD{~VS_POL}};
      hs_pipe  <= {SD{~HS_POL}};
      de_pipe  <= '0;
      vld_pipe <= '0;
    end else begin
      vs_pipe     <= {vs_pipe[SD-1:1], pf.vsync_in};
      hs_pipe     <= {hs_pipe[SD-1:1], pf.hsync_in};
      de_pipe     <= {de_pipe[SD-1:1], pf.de_in};
      vld_pipe[1] <= fifo_rd_c;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign de_d    = de_pipe[RD_LAT];
  assign valid_d = vld_pipe[RD_LAT];
  assign px      = pf.fifo_rdata;

  // Output pixel register: expand by MSB replication, fill on missing data
  always_ff @(posedge pixe_clk or negedge rest_n) begin
    if (!rest_n)
      rgb_q <= 24'h0;
    else if (!de_d)
      rgb_q <= 24'h0;
    else if (valid_d)
      rgb_q <= {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    else
      rgb_q <= FILL_COLOR;
  end

  assign pf.vsync         = vs_pipe[SD];
  assign pf.hsync         = hs_pipe[SD];
  assign pf.de            = de_pipe[SD];
  assign pf.rgb           = rgb_q;
  assign pf.underflow_cnt = ufl_cnt;

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Bench for hdmi_pixel_fetch: two instances (RD_LAT=1 and RD_LAT=3 with the
// underflow counter starting near max) share one timing stream; each has its
// own FIFO model and a frame-level reference model checked every cycle.
module tb_hdmi_pixel_fetch;

  localparam logic [23:0] FILL = 24'h5A3C96;
  localparam int LINE = 12;

  typedef struct packed {
    logic        vs, hs, de, pop;
    logic [23:0] rgb;
    logic [15:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdmi_pixel_fetch_if if1 ();
  hdmi_pixel_fetch_if if3 ();

  hdmi_pixel_fetch #(.RD_LAT(1), .FILL_COLOR(FILL)) dut1 (
    .pixe_clk(clk), .rest_n(rst_n), .pf(if1.slave));
  hdmi_pixel_fetch #(.RD_LAT(3), .FILL_COLOR(FILL), .UFL_INIT(16'hFFFD)) dut3 (
    .pixe_clk(clk), .rest_n(rst_n), .pf(if3.slave));

  logic vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic [15:0] i_rdata[2];
  logic        i_empty[2];
  logic o_rd[2], o_req[2], o_vs[2], o_hs[2], o_de[2];
  logic [23:0] o_rgb[2];
  logic [15:0] o_cnt[2];

  assign if1.vsync_in = vs_i;  assign if3.vsync_in = vs_i;
  assign if1.hsync_in = hs_i;  assign if3.hsync_in = hs_i;
  assign if1.de_in    = de_i;  assign if3.de_in    = de_i;
  assign if1.fifo_rdata = i_rdata[0]; assign if3.fifo_rdata = i_rdata[1];
  assign if1.fifo_empty = i_empty[0]; assign if3.fifo_empty = i_empty[1];
  assign o_rd[0] = if1.fifo_rd;    assign o_rd[1] = if3.fifo_rd;
  assign o_req[0] = if1.frame_req; assign o_req[1] = if3.frame_req;
  assign o_vs[0] = if1.vsync;      assign o_vs[1] = if3.vsync;
  assign o_hs[0] = if1.hsync;      assign o_hs[1] = if3.hsync;
  assign o_de[0] = if1.de;         assign o_de[1] = if3.de;
  assign o_rgb[0] = if1.rgb;       assign o_rgb[1] = if3.rgb;
  assign o_cnt[0] = if1.underflow_cnt; assign o_cnt[1] = if3.underflow_cnt;

  int tests = 0, fails = 0;
  int cyc;
  int rdl[2] = '{1, 3};
  logic [15:0] cnt_init[2] = '{16'h0000, 16'hFFFD};

  // environment: frame buffer, per-instance read pointer and rdata delay line
  logic [15:0] fb[64];
  int          load_n = 0;
  bit          force_empty = 0, glitch = 0;
  int          ptr[2];
  logic [15:0] rdp[2][1:3];
  logic        pop[2], req[2];

  // frame-level reference state
  bit          m_vsp[2], m_inframe[2], m_stream[2], m_fail[2];
  logic [15:0] m_cnt[2];
  exp_t        ring[2][8];
  int          req_cnt[2];
  int          de_rise_cyc;
  logic        prev_de_i, prev_o_de[2];

  function automatic logic [23:0] exp565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h want %0h (cyc %0d)", nm, d, act, want, cyc);
    end
  endtask

  task automatic init_model();
    cyc = 0;
    de_rise_cyc = -1;
    prev_de_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_vsp[d] = 0; m_inframe[d] = 0; m_stream[d] = 0; m_fail[d] = 0;
      m_cnt[d] = cnt_init[d];
      prev_o_de[d] = 1'b0;
    end
  endtask

  task automatic model_check(input int d);
    exp_t e, ex;
    bit lead, erd;
    int L;
    L = rdl[d] + 1;
    chk("underflow_cnt", d, 32'(o_cnt[d]), 32'(m_cnt[d]));
    lead = vs_i && !m_vsp[d];
    erd  = !lead && m_stream[d] && de_i && !i_empty[d];
    chk("fifo_rd", d, 32'(o_rd[d]), 32'(erd));
    chk("frame_req", d, 32'(o_req[d]), 32'(lead));
    if (o_req[d]) req_cnt[d]++;
    e.vs = vs_i; e.hs = hs_i; e.de = de_i; e.pop = erd;
    e.src = erd ? fb[ptr[d]] : 16'h0;
    e.rgb = !de_i ? 24'h0 : (erd ? exp565(e.src) : FILL);
    if (cyc >= L) ex = ring[d][(cyc - L) % 8];
    else ex = '0;
    chk("vsync", d, 32'(o_vs[d]), 32'(ex.vs));
    chk("hsync", d, 32'(o_hs[d]), 32'(ex.hs));
    chk("de", d, 32'(o_de[d]), 32'(ex.de));
    chk("rgb", d, 32'(o_rgb[d]), 32'(ex.rgb));
    if (ex.pop && ex.src == 16'hF800) chk("rgb_red_literal", d, 32'(o_rgb[d]), 32'h00FF0000);
    if (o_de[d] && !prev_o_de[d] && de_rise_cyc >= 0)
      chk("de_latency", d, 32'(cyc - de_rise_cyc), (d == 0) ? 32'd2 : 32'd4);
    prev_o_de[d] = o_de[d];
    ring[d][cyc % 8] = e;
    pop[d] = o_rd[d];
    req[d] = o_req[d];
    // frame rules: restart on vsync edge; first de without a pixel ends the frame
    m_vsp[d] = vs_i;
    if (lead) begin
      m_inframe[d] = 1; m_stream[d] = 0; m_fail[d] = 0;
    end else if (m_inframe[d] && !m_stream[d] && !m_fail[d]) begin
      if (de_i) begin
        m_fail[d] = 1;
        if (m_cnt[d] != 16'hFFFF) m_cnt[d]++;
      end else if (!vs_i && !i_empty[d]) m_stream[d] = 1;
    end else if (m_stream[d] && de_i && i_empty[d]) begin
      m_stream[d] = 0; m_fail[d] = 1;
      if (m_cnt[d] != 16'hFFFF) m_cnt[d]++;
    end
  endtask

  task automatic step();
    if (glitch) force_empty = ($urandom_range(0, 24) == 0);
    for (int d = 0; d < 2; d++) i_empty[d] = force_empty || (ptr[d] >= load_n);
    @(negedge clk);
    if (de_i && !prev_de_i) de_rise_cyc = cyc;
    prev_de_i = de_i;
    for (int d = 0; d < 2; d++) model_check(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k >= 2; k--) rdp[d][k] = rdp[d][k-1];
      rdp[d][1] = pop[d] ? fb[ptr[d] % 64] : 16'($urandom);
      if (pop[d]) ptr[d]++;
      if (req[d]) ptr[d] = 0;
      i_rdata[d] = rdp[d][rdl[d]];
    end
    cyc++;
  endtask

  // one line: hsync for 2, back porch 2, 8 active pixels; vsync active from vsf
  task automatic line(input int vsf, input bit act);
    for (int c = 0; c < LINE; c++) begin
      vs_i = (c >= vsf);
      hs_i = (c < 2);
      de_i = act && (c >= 4);
      step();
    end
  endtask

  task automatic frame(input int nact);
    line(0, 0);
    line(LINE, 0);
    for (int l = 0; l < nact; l++) line(LINE, 1);
    line(LINE, 0);
  endtask

  task automatic set_fb(input int n, input bit rnd);
    load_n = n;
    for (int i = 0; i < 64; i++) fb[i] = rnd ? 16'($urandom) : 16'(i);
    if (!rnd) fb[3] = 16'hF800;
  endtask

  task automatic reset_check();
    for (int d = 0; d < 2; d++) begin
      chk("rst_vsync", d, 32'(o_vs[d]), 32'd0);
      chk("rst_hsync", d, 32'(o_hs[d]), 32'd0);
      chk("rst_de", d, 32'(o_de[d]), 32'd0);
      chk("rst_rgb", d, 32'(o_rgb[d]), 32'd0);
      chk("rst_fifo_rd", d, 32'(o_rd[d]), 32'd0);
      chk("rst_frame_req", d, 32'(o_req[d]), 32'd0);
      chk("rst_cnt", d, 32'(o_cnt[d]), (d == 0) ? 32'h0 : 32'hFFFD);
    end
  endtask

  // asynchronous reset pulse inserted partway through the current cycle
  task automatic mid_reset(input int off);
    #(off);
    rst_n = 1'b0;
    #1;
    reset_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_model();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; req_cnt[d] = 0; i_empty[d] = 1'b1; i_rdata[d] = 16'h0;
      pop[d] = 0; req[d] = 0;
      for (int k = 1; k <= 3; k++) rdp[d][k] = 16'h0;
    end
    set_fb(0, 0);
    @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;
    init_model();

    // T1: counting pattern, two full frames
    set_fb(32, 0);
    line(LINE, 1);            // de before any vsync: stays idle, no pops
    frame(4);
    frame(4);

    // T2: vsync rises while streaming, in horizontal blanking
    line(0, 0); line(LINE, 0); line(LINE, 1); line(LINE, 1);
    req_cnt = '{0, 0};
    line(6, 0); line(0, 0); line(LINE, 0);
    for (int l = 0; l < 4; l++) line(LINE, 1);
    line(LINE, 0);
    chk("t2_req_pulses", 0, 32'(req_cnt[0]), 32'd1);
    chk("t2_req_pulses", 1, 32'(req_cnt[1]), 32'd1);

    // T3: FIFO runs dry at pixel 5 of line 2, then a normal frame
    set_fb(13, 0);
    frame(4);
    chk("t3_cnt", 0, 32'(o_cnt[0]), 32'h1);
    chk("t3_cnt", 1, 32'(o_cnt[1]), 32'hFFFE);
    set_fb(32, 1);
    frame(4);
    chk("t3_cnt_after", 0, 32'(o_cnt[0]), 32'h1);

    // T4: FIFO empty across three frames; second instance saturates
    force_empty = 1;
    for (int f = 0; f < 3; f++) frame(2);
    force_empty = 0;
    chk("t4_cnt", 0, 32'(o_cnt[0]), 32'h4);
    chk("t4_cnt_sat", 1, 32'(o_cnt[1]), 32'hFFFF);

    // T5: reset pulsed in the middle of an active line
    set_fb(32, 1);
    line(0, 0); line(LINE, 0); line(LINE, 1);
    for (int c = 0; c < 7; c++) begin
      vs_i = 0; hs_i = (c < 2); de_i = (c >= 4);
      step();
    end
    mid_reset(2);
    line(LINE, 1);
    frame(4);

    // random frames: random fill levels, pixel data and empty glitches
    for (int f = 0; f < 8; f++) begin
      set_fb($urandom_range(0, 40), 1);
      glitch = (f % 2 == 1);
      for (int x = $urandom_range(0, 5); x > 0; x--) begin
        vs_i = 0; hs_i = 0; de_i = 0;
        step();
      end
      frame($urandom_range(1, 4));
    end
    glitch = 0;
    force_empty = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
